// File: rtl/cool_heat_scheduler_if.sv
// Bundle of request/actuator signals shared by the cool/heat scheduler and
// whatever sequences it (zone controller or testbench).
//   start      : evaluation request, honoured only while the scheduler is idle
//   heat_req   : per-zone heat demand
//   cool_req   : per-zone cool demand
//   heater_on  : heater actuator enable
//   cooler_on  : cooler actuator enable
//   fan_speed  : 0 off, 1 low, 2 mid, 3 high
//   busy       : scheduler is evaluating, in dead time or holding
//   done       : one-cycle pulse when an evaluation completes
// master = requester side, slave = scheduler side.
interface cool_heat_scheduler_if #(
    parameter int N_ZONES = 8
);
    logic                start;
    logic [N_ZONES-1:0]  heat_req;
    logic [N_ZONES-1:0]  cool_req;
    logic                heater_on;
    logic                cooler_on;
    logic [1:0]          fan_speed;
    logic                busy;
    logic                done;

    modport master (
        output start, heat_req, cool_req,
        input  heater_on, cooler_on, fan_speed, busy, done
    );

    modport slave (
        input  start, heat_req, cool_req,
        output heater_on, cooler_on, fan_speed, busy, done
    );
endinterface

// File: rtl/cool_heat_scheduler.sv
// Cool/heat plant sequencer.
// Each evaluation latches the zone request vectors, counts exclusive heat and
// cool requests, votes a mode (OFF/HEAT/COOL) with fan speed and drives the
// actuators while protecting the compressor: a newly started mode is held for
// MIN_ON cycles and any HEAT<->COOL reversal inserts DEADTIME cycles with both
// actuators off.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset; drops actuators immediately
//   bus    : cool_heat_scheduler_if.slave (start, heat_req, cool_req in;
//            heater_on, cooler_on, fan_speed, busy, done out, all registered)
module cool_heat_scheduler #(
    parameter int N_ZONES  = 8,
    parameter int THRESH   = 2,
    parameter int MIN_ON   = 16,
    parameter int DEADTIME = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cool_heat_scheduler_if.slave      bus
);

    localparam int PC_W  = $clog2(N_ZONES + 1);
    localparam int CNT_W = $clog2(MIN_ON + DEADTIME + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_COUNT  = 3'd1;
    localparam logic [2:0] S_DECIDE = 3'd2;
    localparam logic [2:0] S_DEAD   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_HEAT = 2'd1;
    localparam logic [1:0] MODE_COOL = 2'd2;

    localparam logic [PC_W-1:0]  THRESH_C    = PC_W'(THRESH);
    localparam logic [PC_W-1:0]  FAN_LOW_MAX = PC_W'(2);
    localparam logic [PC_W-1:0]  FAN_MID_MAX = PC_W'(5);
    localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEADTIME - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    // Number of set bits in a zone vector.
    function automatic logic [PC_W-1:0] popcount(input logic [N_ZONES-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < N_ZONES; i++) begin
            n = n + {{(PC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [2:0]         r_state;
    logic [1:0]         r_mode;
    logic [1:0]         r_pend_mode;
    logic [1:0]         r_pend_fan;
    logic [N_ZONES-1:0] r_h;
    logic [N_ZONES-1:0] r_c;
    logic [PC_W-1:0]    r_hc;
    logic [PC_W-1:0]    r_cc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_heater;
    logic               r_cooler;
    logic [1:0]         r_fan;
    logic               r_busy;
    logic               r_done;

    logic [1:0]         w_new_mode;
    logic [1:0]         w_new_fan;
    logic [PC_W-1:0]    w_max;
    logic               w_reversal;

    // Mode vote and fan level from the registered request counts.
    always_comb begin
        w_new_mode = MODE_OFF;
        w_new_fan  = 2'd0;
        w_max      = (r_hc > r_cc) ? r_hc : r_cc;

        // Ties fall through to OFF because neither strict comparison holds.
        if ((r_hc > r_cc) && (r_hc >= THRESH_C)) begin
            w_new_mode = MODE_HEAT;
        end else if ((r_cc > r_hc) && (r_cc >= THRESH_C)) begin
            w_new_mode = MODE_COOL;
        end else begin
            w_new_mode = MODE_OFF;
        end

        if (w_new_mode == MODE_OFF) begin
            w_new_fan = 2'd0;
        end else if (w_max <= FAN_LOW_MAX) begin
            w_new_fan = 2'd1;
        end else if (w_max <= FAN_MID_MAX) begin
            w_new_fan = 2'd2;
        end else begin
            w_new_fan = 2'd3;
        end

        w_reversal = ((r_mode == MODE_HEAT) && (w_new_mode == MODE_COOL)) ||
                     ((r_mode == MODE_COOL) && (w_new_mode == MODE_HEAT));
    end

    // Sequencer state, counters and registered actuator outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= MODE_OFF;
            r_pend_mode <= MODE_OFF;
            r_pend_fan  <= 2'd0;
            r_h         <= {N_ZONES{1'b0}};
            r_c         <= {N_ZONES{1'b0}};
            r_hc        <= {PC_W{1'b0}};
            r_cc        <= {PC_W{1'b0}};
            r_cnt       <= CNT_ZERO;
            r_heater    <= 1'b0;
            r_cooler    <= 1'b0;
            r_fan       <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Zones asking for both heat and cool cancel out.
                        r_h     <= bus.heat_req & ~bus.cool_req;
                        r_c     <= bus.cool_req & ~bus.heat_req;
                        r_busy  <= 1'b1;
                        r_state <= S_COUNT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_COUNT: begin
                    r_hc    <= popcount(r_h);
                    r_cc    <= popcount(r_c);
                    r_state <= S_DECIDE;
                end
                S_DECIDE: begin
                    if (w_reversal) begin
                        // Both actuators off; the new mode is applied after dead time.
                        r_heater    <= 1'b0;
                        r_cooler    <= 1'b0;
                        r_fan       <= 2'd0;
                        r_pend_mode <= w_new_mode;
                        r_pend_fan  <= w_new_fan;
                        r_cnt       <= DEAD_LOAD;
                        r_state     <= S_DEAD;
                    end else if ((w_new_mode == r_mode) && (w_new_mode != MODE_OFF)) begin
                        // Compressor already running in this mode: no new hold.
                        r_fan   <= w_new_fan;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_new_mode != MODE_OFF) begin
                        r_heater <= (w_new_mode == MODE_HEAT);
                        r_cooler <= (w_new_mode == MODE_COOL);
                        r_fan    <= w_new_fan;
                        r_mode   <= w_new_mode;
                        r_cnt    <= HOLD_LOAD;
                        r_state  <= S_HOLD;
                    end else begin
                        r_heater <= 1'b0;
                        r_cooler <= 1'b0;
                        r_fan    <= 2'd0;
                        r_mode   <= MODE_OFF;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_DEAD: begin
                    if (r_cnt == CNT_ZERO) begin
                        r_heater <= (r_pend_mode == MODE_HEAT);
                        r_cooler <= (r_pend_mode == MODE_COOL);
                        r_fan    <= r_pend_fan;
                        r_mode   <= r_pend_mode;
                        r_cnt    <= HOLD_LOAD;
                        r_state  <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CNT_ZERO) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mode   <= MODE_OFF;
                    r_heater <= 1'b0;
                    r_cooler <= 1'b0;
                    r_fan    <= 2'd0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.heater_on = r_heater;
    assign bus.cooler_on = r_cooler;
    assign bus.fan_speed = r_fan;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_cool_heat_scheduler.sv
// Testbench for cool_heat_scheduler: directed scenarios plus randomized
// request vectors checked cycle by cycle against a timeline model derived
// from the mode vote, fan table, hold time and dead time rules.
module tb_cool_heat_scheduler;

    localparam int DEAD = 8;
    localparam int HOLD = 16;
    localparam int THR  = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cool_heat_scheduler_if bif ();

    cool_heat_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the plant state: 0 off, 1 heat, 2 cool.
    int         m_mode   = 0;
    logic       m_heater = 1'b0;
    logic       m_cooler = 1'b0;
    logic [1:0] m_fan    = 2'd0;

    function automatic logic [5:0] observe();
        return {bif.heater_on, bif.cooler_on, bif.fan_speed, bif.busy, bif.done};
    endfunction

    // One evaluation from the idle state, checked every cycle until one cycle
    // after done. glitch_k: cycle at which a stray start is driven (-1 none).
    // abort_k: cycle at which reset is asserted mid-operation (-1 none).
    task automatic run_eval(input logic [7:0] h, input logic [7:0] c,
                            input string name, input int glitch_k, input int abort_k);
        int hc, cc, mx, nm, lat;
        logic [1:0] nf;
        logic nh, ncl, rev;
        logic [5:0] exp_v, got_v;
        hc = $countones(h & ~c);
        cc = $countones(c & ~h);
        mx = (hc > cc) ? hc : cc;
        if (hc > cc && hc >= THR) nm = 1;
        else if (cc > hc && cc >= THR) nm = 2;
        else nm = 0;
        if (nm == 0) nf = 2'd0;
        else if (mx <= 2) nf = 2'd1;
        else if (mx <= 5) nf = 2'd2;
        else nf = 2'd3;
        nh  = (nm == 1);
        ncl = (nm == 2);
        rev = (m_mode == 1 && nm == 2) || (m_mode == 2 && nm == 1);
        if (rev) lat = 2 + DEAD + HOLD;
        else if (nm != 0 && nm == m_mode) lat = 2;
        else if (nm != 0) lat = 2 + HOLD;
        else lat = 2;

        bif.heat_req = h;
        bif.cool_req = c;
        bif.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= lat + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (k == abort_k) begin
                rst_n = 1'b0;
                bif.start = 1'b0;
                #1;
                got_v = observe();
                n_vec++;
                if (got_v !== 6'b000000) begin
                    n_err++;
                    $display("FAIL %s abort got %b expected 000000", name, got_v);
                end
                m_mode = 0; m_heater = 1'b0; m_cooler = 1'b0; m_fan = 2'd0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                @(negedge clk);
                got_v = observe();
                n_vec++;
                if (got_v !== 6'b000000) begin
                    n_err++;
                    $display("FAIL %s after_abort got %b expected 000000", name, got_v);
                end
                return;
            end
            if (k < 2) exp_v[5:2] = {m_heater, m_cooler, m_fan};
            else if (rev && k < 2 + DEAD) exp_v[5:2] = 4'b0000;
            else exp_v[5:2] = {nh, ncl, nf};
            exp_v[1] = (k < lat);
            exp_v[0] = (k == lat);
            got_v = observe();
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL %s k=%0d got {heat,cool,fan,busy,done}=%b expected %b",
                         name, k, got_v, exp_v);
            end
            bif.start = (k == glitch_k);
            if (k == glitch_k) begin
                bif.heat_req = ~h;
                bif.cool_req = 8'hFF;
            end
        end
        bif.start = 1'b0;
        m_mode = nm; m_heater = nh; m_cooler = ncl; m_fan = nf;
    endtask

    task automatic test_reset();
        logic [5:0] got_v;
        rst_n = 1'b0;
        bif.start = 1'b1;
        bif.heat_req = 8'hFF;
        bif.cool_req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got_v = observe();
            n_vec++;
            if (got_v !== 6'b000000) begin
                n_err++;
                $display("FAIL reset cycle=%0d got %b expected 000000", i, got_v);
            end
        end
        bif.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        got_v = observe();
        n_vec++;
        if (got_v !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_release got %b expected 000000", got_v);
        end
    endtask

    task automatic test_heat_start();
        run_eval(8'h0F, 8'h00, "heat_start", -1, -1);
    endtask

    task automatic test_reversal();
        run_eval(8'h00, 8'hFF, "reversal", -1, -1);
    endtask

    task automatic test_tie();
        run_eval(8'h03, 8'h0C, "tie", -1, -1);
    endtask

    task automatic test_threshold_conflict();
        run_eval(8'h01, 8'h00, "below_thresh", -1, -1);
        run_eval(8'hFF, 8'hFF, "all_conflict", -1, -1);
    endtask

    task automatic test_start_ignored_and_abort();
        logic [5:0] got_v, exp_v;
        run_eval(8'h0F, 8'h00, "start_in_hold", 5, -1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = {m_heater, m_cooler, m_fan, 2'b00};
            got_v = observe();
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL no_extra_done cycle=%0d got %b expected %b", i, got_v, exp_v);
            end
        end
        run_eval(8'h00, 8'h00, "to_off", -1, -1);
        run_eval(8'h3F, 8'h00, "abort_hold", -1, 8);
    endtask

    task automatic test_back_to_back();
        run_eval(8'h0F, 8'h00, "b2b_heat", -1, -1);
        run_eval(8'hFF, 8'h00, "b2b_same_mode", -1, -1);
        run_eval(8'h00, 8'h07, "b2b_reverse", -1, -1);
    endtask

    task automatic test_random();
        logic [7:0] h, c;
        int sel;
        for (int i = 0; i < 30; i++) begin
            h = 8'($urandom);
            c = 8'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 1) c = 8'h00;
            else if (sel == 2) h = 8'h00;
            else if (sel == 3) c = c & ~h;
            run_eval(h, c, "random", -1, -1);
        end
    endtask

    initial begin
        bif.start    = 1'b0;
        bif.heat_req = 8'h00;
        bif.cool_req = 8'h00;
        test_reset();
        test_heat_start();
        test_reversal();
        test_tie();
        test_threshold_conflict();
        test_start_ignored_and_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
